mem_xfer_unit: RTL and testbench
================================

// Module: mem_xfer_unit
// PURPOSE
//  Sequential, parametrised load/store unit between the CPU execute stage and the Avalon-MM data bus.
//  Accepts one request per handshake, issues exactly one bus read or write, holds it through waitrequest,
//  and returns an extended/merged load result or store completion.
//  Generates per-lane byteenable and little-endian lane steering for byte, half and word accesses, plus LWL/LWR merge.
// PARAMETERS
//  DATA_W  32  bus/register width; 32 or 64 only; LANES = DATA_W/8
//  ADDR_W  32  byte address width
// PORTS
//  clk          in   1        clock; all state changes on rising edge
//  reset        in   1        synchronous, active-high
//  req_valid    in   1        request present
//  req_ready    out  1        unit can accept (high only in IDLE)
//  req_op       in   4        mxu_pkg::mem_op_t (LB,LBU,LH,LHU,LW,LWL,LWR,SB,SH,SW)
//  req_addr     in   ADDR_W   effective byte address
//  req_wdata    in   DATA_W   store data (rt)
//  req_rt_old   in   DATA_W   current rt value; merge source for LWL/LWR
//  rsp_valid    out  1        one-cycle completion pulse; no backpressure
//  rsp_rdata    out  DATA_W   load result (0 for stores)
//  rsp_err      out  1        misaligned-access flag (valid with rsp_valid)
//  address      out  ADDR_W   bus address, low log2(LANES) bits forced 0
//  read, write  out  1 each   bus strobes; never both high
//  writedata    out  DATA_W   lane-steered store data
//  byteenable   out  LANES    active lanes
//  waitrequest  in   1        slave stall
//  readdata     in   DATA_W   valid the cycle after a read is accepted
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid, rsp_err, read, write=0; address, writedata, byteenable, rsp_rdata=0.
//  FSM: IDLE -(req_valid)-> ISSUE; ISSUE holds read|write, address, writedata, byteenable constant while waitrequest=1.
//   ISSUE -(waitrequest=0, store)-> DONE; ISSUE -(waitrequest=0, load)-> CAPTURE.
//   CAPTURE: register readdata, extract/merge -> DONE.
//   DONE: rsp_valid=1 for exactly one cycle -> IDLE.
//  Minimum latency: store, accept to rsp_valid = 2 cycles; load = 3 cycles; each waitrequest cycle adds 1.
//  Request fields are registered at acceptance; later input changes are ignored.
//  Lane steering: off = addr[log2(LANES)-1:0]; byte b of the word occupies lane b (little-endian).
//   SB: lane off, be = 1<<off. SH/LH/LHU: lanes off,off+1; be = 2'b11<<off.
//   SW/LW: all lanes. Halfword/word within DATA_W=64 use off aligned to 2/4 bytes.
//  LB/LH sign-extend to DATA_W; LBU/LHU zero-extend. LW with DATA_W=64 sign-extends the 32-bit word.
//  LWL: the result's top (off+1) bytes are memory lanes off..0; the remaining bytes come from req_rt_old. be = lanes 0..off.
//  LWR: the result's low (LANES-off) bytes are memory lanes off..LANES-1; the remaining bytes come from req_rt_old.
//   be = lanes off..LANES-1.
//  Unused writedata lanes are 0. rsp_rdata holds its value until the next load completes.
//  Reset mid-transaction, including during waitrequest: read/write drop at that edge, state=IDLE, no rsp_valid.
//  req_valid while busy: not accepted; req_ready=0 from ISSUE through DONE; no queueing.
// CONFIGURATION
//  MXU_MISALIGN_TRAP_EN defined:
//   - A halfword op with addr[0]=1, or a word op (LW, SW) with addr not 4-aligned, issues no bus cycle.
//   - Such a request goes IDLE -> DONE with rsp_err=1 and rsp_rdata=0 (accept to rsp_valid = 2 cycles).
//  Undefined: rsp_err is tied 0; misaligned low address bits are truncated to natural alignment and the access proceeds.
// STRUCTURE
//  mxu_pkg: mem_op_t enum, state_t (IDLE, ISSUE, CAPTURE, DONE), LANES/OFF_W localparams, is_load()/is_misaligned() functions.
//  Sub-module mxu_lane_align: combinational byteenable/writedata steering and load extract/merge.
//  The top module holds the FSM and registers only.
// TESTING
//  LB addr 0x1003, readdata 0x80FF_FF00 -> be 4'b1000, rsp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
//  SH addr 0x2002, wdata 0x1234_ABCD -> write=1, be 4'b1100, writedata 0xABCD_0000, rsp_valid at cycle 2.
//  SW with waitrequest high 3 cycles -> strobes/address stable 4 cycles, rsp_valid 5 cycles after accept, single write.
//  LWL off=1, readdata 0x4433_2211, rt_old 0xAAAA_AAAA -> 0x2211_AAAA; LWR off=1 -> 0xAA44_3322.
//  reset asserted during waitrequest on LW -> read=0 next edge, no rsp_valid, req_ready=1, then next LW completes normally.
//  With MXU_MISALIGN_TRAP_EN: LW addr 0x1001 -> read never asserted, rsp_valid and rsp_err=1 at cycle 2.
//   Without the macro: read at 0x1000.

Source files
------------

// File: rtl/mxu_pkg.sv
// mxu_pkg - shared types and helpers for the memory transfer unit.
//   mem_op_t : load/store opcodes carried on req_op (4 bits)
//   state_t  : transfer FSM states
//   LANES / OFF_W : lane count and lane-offset width for the default 32-bit bus
//   is_load(), is_misaligned(), acc_bytes() : opcode classification helpers
package mxu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd7,
        OP_SH  = 4'd8,
        OP_SW  = 4'd9
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int LANES      = DATA_W_DEF / 8;
    localparam int OFF_W      = $clog2(LANES);

    function automatic logic is_load(input mem_op_t op);
        return !(op == OP_SB || op == OP_SH || op == OP_SW);
    endfunction

    // Natural access size in bytes. LWL/LWR report 1 so that their offset
    // passes through the alignment mask untouched.
    function automatic logic [3:0] acc_bytes(input mem_op_t op);
        case (op)
            OP_LH, OP_LHU, OP_SH: return 4'd2;
            OP_LW, OP_SW:         return 4'd4;
            default:              return 4'd1;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
        case (op)
            OP_LH, OP_LHU, OP_SH: return lo[0];
            OP_LW, OP_SW:         return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mxu_lane_align.sv
// mxu_lane_align - combinational lane steering for the memory transfer unit.
//   op, off   : opcode and byte offset within the bus word
//   wdata     : store data (right-justified)   -> wdata_out : lane-steered, unused lanes 0
//   rdata     : bus read data, rt_old : merge source -> ldata : extended/merged load result
//   be        : byte enables for the access
// Halfword/word accesses use the offset truncated to natural alignment.
module mxu_lane_align
    import mxu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NL     = DATA_W / 8,
    localparam int OW     = $clog2(NL)
) (
    input  mem_op_t           op,
    input  logic [OW-1:0]     off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] rt_old,
    output logic [NL-1:0]     be,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] ldata
);

    localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};

    logic [3:0]        nbytes;
    logic [OW-1:0]     aoff;
    logic [NL-1:0]     size_be;
    logic [DATA_W-1:0] shifted;
    int                sh_a;
    int                sh_m;

    always_comb begin
        nbytes    = acc_bytes(op);
        aoff      = off & ~OW'(nbytes - 4'd1);
        sh_a      = 8 * int'(aoff);
        size_be   = NL'((1 << nbytes) - 1);
        shifted   = rdata >> sh_a;
        sh_m      = 0;
        be        = '0;
        wdata_out = '0;
        ldata     = '0;
        case (op)
            // Unaligned-left: memory lanes off..0 land in the top bytes.
            OP_LWL: begin
                sh_m  = 8 * (NL - 1 - int'(off));
                be    = {NL{1'b1}} >> (NL - 1 - int'(off));
                ldata = (rdata << sh_m) | (rt_old & ~(ONES << sh_m));
            end
            // Unaligned-right: memory lanes off..NL-1 land in the low bytes.
            OP_LWR: begin
                sh_m  = 8 * int'(off);
                be    = {NL{1'b1}} << off;
                ldata = (rdata >> sh_m) | (rt_old & ~(ONES >> sh_m));
            end
            default: begin
                be = size_be << aoff;
                if (!is_load(op))
                    wdata_out = (wdata & ~(ONES << (8 * int'(nbytes)))) << sh_a;
                case (op)
                    OP_LB:  begin ldata = {DATA_W{shifted[7]}};  ldata[7:0]  = shifted[7:0];  end
                    OP_LBU: begin ldata = '0;                    ldata[7:0]  = shifted[7:0];  end
                    OP_LH:  begin ldata = {DATA_W{shifted[15]}}; ldata[15:0] = shifted[15:0]; end
                    OP_LHU: begin ldata = '0;                    ldata[15:0] = shifted[15:0]; end
                    OP_LW:  begin ldata = {DATA_W{shifted[31]}}; ldata[31:0] = shifted[31:0]; end
                    default: ldata = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mem_xfer_unit.sv
// mem_xfer_unit - sequential load/store unit between execute and an Avalon-MM data bus.
//   req_*      : request handshake (req_ready high only when idle)
//   rsp_*      : one-cycle completion pulse with load result and misalign flag
//   address/read/write/writedata/byteenable/waitrequest/readdata : Avalon-MM master
// Build option: MXU_MISALIGN_TRAP_EN - misaligned halfword/word requests complete with
// rsp_err=1 and no bus cycle; otherwise they are truncated to natural alignment.
module mem_xfer_unit
    import mxu_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    localparam int NL     = DATA_W / 8,
    localparam int OW     = $clog2(NL)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_rt_old,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [NL-1:0]     byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    state_t            state_q, state_d;
    mem_op_t           op_q, op_d;
    logic [OW-1:0]     off_q, off_d;
    logic [DATA_W-1:0] rt_old_q, rt_old_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [NL-1:0]     be_q, be_d;

    mem_op_t           req_op_e;
    mem_op_t           op_sel;
    logic [OW-1:0]     off_sel;
    logic [NL-1:0]     be_w;
    logic [DATA_W-1:0] wdata_w;
    logic [DATA_W-1:0] ldata_w;
    logic              trap_w;

    assign req_op_e = mem_op_t'(req_op);

`ifdef MXU_MISALIGN_TRAP_EN
    assign trap_w = is_misaligned(req_op_e, req_addr[1:0]);
`else
    assign trap_w = 1'b0;
`endif

    // One aligner serves both directions: steering uses the live request in
    // IDLE, extract/merge uses the registered request in CAPTURE.
    assign op_sel  = (state_q == ST_IDLE) ? req_op_e : op_q;
    assign off_sel = (state_q == ST_IDLE) ? req_addr[OW-1:0] : off_q;

    mxu_lane_align #(.DATA_W(DATA_W)) u_align (
        .op        (op_sel),
        .off       (off_sel),
        .wdata     (req_wdata),
        .rdata     (readdata),
        .rt_old    (rt_old_q),
        .be        (be_w),
        .wdata_out (wdata_w),
        .ldata     (ldata_w)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        rt_old_d    = rt_old_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        address_d   = address_q;
        read_d      = read_q;
        write_d     = write_q;
        writedata_d = writedata_q;
        be_d        = be_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op_e;
                    off_d       = req_addr[OW-1:0];
                    rt_old_d    = req_rt_old;
                    err_d       = trap_w;
                    req_ready_d = 1'b0;
                    state_d     = ST_ISSUE;
                    if (!trap_w) begin
                        address_d   = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
                        read_d      = is_load(req_op_e);
                        write_d     = !is_load(req_op_e);
                        writedata_d = wdata_w;
                        be_d        = be_w;
                    end
                end
            end
            ST_ISSUE: begin
                // A trapped request spends this cycle with the strobes low so
                // its completion latency matches a store.
                if (err_q) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (!waitrequest) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    address_d   = '0;
                    writedata_d = '0;
                    be_d        = '0;
                    if (is_load(op_q)) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                    end
                end
            end
            ST_CAPTURE: begin
                rsp_rdata_d = ldata_w;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                rsp_err_d   = 1'b0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LB;
            off_q       <= '0;
            rt_old_q    <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            address_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            writedata_q <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rt_old_q    <= rt_old_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            address_q   <= address_d;
            read_q      <= read_d;
            write_q     <= write_d;
            writedata_q <= writedata_d;
            be_q        <= be_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = be_q;

endmodule

// File: tb/tb_mem_xfer_unit.sv
// tb_mem_xfer_unit - randomized self-checking bench for mem_xfer_unit (DATA_W=32).
// A byte-level reference model plus a cycle timeline of the bus protocol drive
// the expected outputs; one negedge process compares them every cycle.
module tb_mem_xfer_unit;
    import mxu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_rt_old = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] address, writedata;
    logic        read, write;
    logic [3:0]  byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;

    mem_xfer_unit #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int strobe_cnt = 0;
    logic chk_en = 1'b0;

    // expected outputs for the current cycle
    logic        m_ready = 1'b1, m_read = 1'b0, m_write = 1'b0, m_rsp_valid = 1'b0;
    logic        m_err = 1'b0, m_rd_chk = 1'b0;
    logic [31:0] m_addr = '0, m_wd = '0, m_rdata = '0;
    logic [3:0]  m_be = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            chk("read",      32'(read),      32'(m_read));
            chk("write",     32'(write),     32'(m_write));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            if (m_read || m_write) begin
                chk("address",    address,          m_addr);
                chk("byteenable", 32'(byteenable),  32'(m_be));
                chk("writedata",  writedata,        m_wd);
            end
            if (m_rsp_valid) begin
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
                if (m_rd_chk) chk("rsp_rdata", rsp_rdata, m_rdata);
            end
            if (read || write) strobe_cnt++;
        end
    end

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic logic op_is_load(input mem_op_t op);
        return !(op == OP_SB || op == OP_SH || op == OP_SW);
    endfunction

    function automatic logic ref_trap(input mem_op_t op, input logic [1:0] a);
        logic mis;
        mis = ((op == OP_LH || op == OP_LHU || op == OP_SH) && a[0]) ||
              ((op == OP_LW || op == OP_SW) && a != 2'b00);
`ifdef MXU_MISALIGN_TRAP_EN
        return mis;
`else
        return 1'b0 & mis;
`endif
    endfunction

    function automatic logic [3:0] ref_be(input mem_op_t op, input logic [1:0] a);
        logic [3:0] be;
        be = '0;
        for (int i = 0; i < 4; i++) begin
            case (op)
                OP_LB, OP_LBU, OP_SB: be[i] = (i == int'(a));
                OP_LH, OP_LHU, OP_SH: be[i] = (i / 2 == int'(a) / 2);
                OP_LWL:               be[i] = (i <= int'(a));
                OP_LWR:               be[i] = (i >= int'(a));
                default:              be[i] = 1'b1;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] ref_wd(input mem_op_t op, input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] r;
        int b;
        r = '0;
        case (op)
            OP_SB: r[8*int'(a) +: 8] = wd[7:0];
            OP_SH: begin b = (int'(a) / 2) * 2; r[8*b +: 16] = wd[15:0]; end
            OP_SW: r = wd;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_ld(input mem_op_t op, input logic [1:0] a,
                                           input logic [31:0] rd, input logic [31:0] rt);
        logic [7:0]  m [4];
        logic [15:0] h;
        logic [31:0] r;
        int ai;
        ai = int'(a);
        for (int i = 0; i < 4; i++) m[i] = rd[8*i +: 8];
        h = {m[(ai/2)*2 + 1], m[(ai/2)*2]};
        r = '0;
        case (op)
            OP_LB:  r = {{24{m[ai][7]}}, m[ai]};
            OP_LBU: r = {24'd0, m[ai]};
            OP_LH:  r = {{16{h[15]}}, h};
            OP_LHU: r = {16'd0, h};
            OP_LW:  r = rd;
            OP_LWL: begin r = rt; for (int j = 0; j <= ai; j++) r[8*(3-j) +: 8] = m[ai-j]; end
            OP_LWR: begin r = rt; for (int j = 0; j <= 3 - ai; j++) r[8*j +: 8] = m[ai+j]; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- stimulus ----------------
    task automatic scramble();
        req_valid  = 1'($urandom % 2);
        req_op     = 4'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rt_old = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rt, input logic [31:0] rd, input int nwait,
                           output logic [31:0] g_rdata, output logic [3:0] g_be,
                           output logic [31:0] g_wd, output logic [31:0] g_addr,
                           output logic g_err, output int g_strobes);
        logic ld, trap;
        ld   = op_is_load(op);
        trap = ref_trap(op, addr[1:0]);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
        readdata = $urandom; waitrequest = 1'($urandom % 2);
        m_ready = 1'b1; m_read = 1'b0; m_write = 1'b0; m_rsp_valid = 1'b0;
        tick();
        strobe_cnt = 0;
        scramble();
        m_ready = 1'b0;
        g_be = byteenable; g_wd = writedata; g_addr = address;
        if (!trap) begin
            m_addr = {addr[31:2], 2'b00};
            m_be = ref_be(op, addr[1:0]);
            m_wd = ref_wd(op, addr[1:0], wd);
            m_read = ld; m_write = !ld;
            for (int w = 0; w <= nwait; w++) begin
                waitrequest = (w < nwait);
                readdata = $urandom;
                tick();
                scramble();
            end
            m_read = 1'b0; m_write = 1'b0;
            waitrequest = 1'($urandom % 2);
            if (ld) begin
                readdata = rd;
                tick();
                scramble();
                readdata = $urandom;
            end
        end else begin
            tick();
            scramble();
        end
        m_rsp_valid = 1'b1; m_err = trap; m_rd_chk = ld || trap;
        m_rdata = trap ? 32'd0 : ref_ld(op, addr[1:0], rd, rt);
        g_rdata = rsp_rdata; g_err = rsp_err;
        tick();
        g_strobes = strobe_cnt;
        m_rsp_valid = 1'b0; m_ready = 1'b1; req_valid = 1'b0;
    endtask

    logic [31:0] g_rdata, g_wd, g_addr;
    logic [3:0]  g_be;
    logic        g_err;
    int          g_str;

    initial begin
        // reset state
        tick(); tick();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_strobes",   32'({read, write}), 32'd0);
        chk("rst_address",   address, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_be",        32'(byteenable), 32'd0);
        chk("rst_rdata",     rsp_rdata, 32'd0);
        reset = 1'b0;
        chk_en = 1'b1;

        run_txn(OP_LB, 32'h1003, 0, 0, 32'h80FF_FF00, 0, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        chk("lb_be", 32'(g_be), 32'h8);
        chk("lb_rdata", g_rdata, 32'hFFFF_FF80);
        run_txn(OP_LBU, 32'h1003, 0, 0, 32'h80FF_FF00, 0, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        chk("lbu_rdata", g_rdata, 32'h0000_0080);
        run_txn(OP_SH, 32'h2002, 32'h1234_ABCD, 0, 0, 0, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        chk("sh_be", 32'(g_be), 32'hC);
        chk("sh_wd", g_wd, 32'hABCD_0000);
        chk("sh_addr", g_addr, 32'h2000);
        run_txn(OP_SW, 32'h3000, 32'hDEAD_BEEF, 0, 0, 3, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        chk("sw_wait_strobe_cycles", 32'(g_str), 32'd4);
        run_txn(OP_LWL, 32'h4001, 0, 32'hAAAA_AAAA, 32'h4433_2211, 0, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        chk("lwl_rdata", g_rdata, 32'h2211_AAAA);
        chk("lwl_be", 32'(g_be), 32'h3);
        run_txn(OP_LWR, 32'h4001, 0, 32'hAAAA_AAAA, 32'h4433_2211, 1, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        chk("lwr_rdata", g_rdata, 32'hAA44_3322);
        chk("lwr_be", 32'(g_be), 32'hE);

        // reset in the middle of a stalled LW
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h5000; waitrequest = 1'b1;
        m_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        m_ready = 1'b0; m_read = 1'b1; m_addr = 32'h5000; m_be = 4'hF; m_wd = 32'd0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; waitrequest = 1'b0;
        m_read = 1'b0; m_ready = 1'b1;
        chk("rst_mid_read", 32'(read), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        repeat (3) tick();
        run_txn(OP_LW, 32'h5004, 0, 0, 32'h1357_9BDF, 0, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        chk("lw_after_rst", g_rdata, 32'h1357_9BDF);

        run_txn(OP_LW, 32'h1001, 0, 0, 32'h0BAD_F00D, 0, g_rdata, g_be, g_wd, g_addr, g_err, g_str);
`ifdef MXU_MISALIGN_TRAP_EN
        chk("trap_err", 32'(g_err), 32'd1);
        chk("trap_no_read", 32'(g_str), 32'd0);
`else
        chk("mis_addr", g_addr, 32'h1000);
        chk("mis_rdata", g_rdata, 32'h0BAD_F00D);
`endif

        for (int n = 0; n < 400; n++) begin
            run_txn(mem_op_t'($urandom_range(0, 9)), $urandom, $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), g_rdata, g_be, g_wd, g_addr, g_err, g_str);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
